// File: rtl/div_controller.sv
// Sequencing FSM for the restoring fixed-point divider datapath.
// Optional build macro DIV_EARLY_ABORT_EN: a zero divisor skips straight from LOAD to DONE.
module div_controller #(
   parameter int unsigned ITERS = 14,
   parameter int unsigned CNT_W = 4
) (
   input  logic clk,
   input  logic sclr,
   input  logic start,
   output logic ready,
   output logic done,
   output logic dvz_err,
   output logic ovf_err,
   input  logic lt,
   input  logic ovf_from_dp,
   input  logic dvz,
   output logic ld_a,
   output logic ld_b,
   output logic iz,
   output logic sel_sub,
   output logic shen_acc,
   output logic shen_q
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      INIT,
      ITER,
      RESULT,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge sclr) begin
      if (sclr) state <= IDLE;
      else      state <= state_nxt;
   end

   // Flags are cleared only when a new request is accepted, so they stay readable after done.
   always_ff @(posedge clk or posedge sclr) begin
      if (sclr) begin
         cnt     <= '0;
         dvz_err <= 1'b0;
         ovf_err <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  dvz_err <= 1'b0;
                  ovf_err <= 1'b0;
               end
            end
            LOAD:    dvz_err <= dvz;
            INIT:    cnt     <= '0;
            ITER:    cnt     <= cnt + CNT_W'(1);
            RESULT:  ovf_err <= ovf_from_dp;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      done      = 1'b0;
      ld_a      = 1'b0;
      ld_b      = 1'b0;
      iz        = 1'b0;
      sel_sub   = 1'b0;
      shen_acc  = 1'b0;
      shen_q    = 1'b0;
      unique case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) state_nxt = LOAD;
         end
         LOAD: begin
            ld_a = 1'b1;
            ld_b = 1'b1;
`ifdef DIV_EARLY_ABORT_EN
            state_nxt = dvz ? DONE : INIT;
`else
            state_nxt = INIT;
`endif
         end
         INIT: begin
            iz        = 1'b1;
            state_nxt = ITER;
         end
         ITER: begin
            shen_acc = 1'b1;
            shen_q   = 1'b1;
            sel_sub  = lt;
            if (cnt == LAST) state_nxt = RESULT;
         end
         RESULT: state_nxt = DONE;
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
